prt_riscv_cpu_wb: RTL

Register writeback unit for the RISC-V CPU: the single writer of the CPU register file. It merges single-cycle ALU results with in-order, variable-latency load responses, tracks outstanding load destinations in a small queue, drives the register file write port, and provides hazard and forwarding flags to the decode stage. It sits between the execute/load-store units and the register file write port.

---
 rtl/prt_riscv_cpu_wb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/prt_riscv_cpu_wb.sv
// Register writeback unit: merges ALU results with in-order load responses
// and drives the single register file write port plus decode hazard flags.
module prt_riscv_cpu_wb #(
  parameter int P_IDX      = 4,
  parameter int P_LQ_DEPTH = 4
) (
  input  logic             CLK_IN,
  input  logic             RST_IN,
  input  logic [P_IDX-1:0] ALU_IDX_IN,
  input  logic [31:0]      ALU_DAT_IN,
  input  logic             ALU_VLD_IN,
  input  logic             LD_ISSUE_IN,
  input  logic [P_IDX-1:0] LD_ISSUE_IDX_IN,
  output logic             LD_RDY_OUT,
  input  logic [31:0]      LD_DAT_IN,
  input  logic             LD_VLD_IN,
  output logic [P_IDX-1:0] RD_IDX_OUT,
  output logic [31:0]      RD_DAT_OUT,
  output logic             RD_WR_OUT,
  input  logic [P_IDX-1:0] DEC_RS1_IDX_IN,
  input  logic [P_IDX-1:0] DEC_RS2_IDX_IN,
  input  logic [P_IDX-1:0] DEC_RD_IDX_IN,
  output logic             HAZ_OUT,
  output logic             RS1_FWD_OUT,
  output logic             RS2_FWD_OUT,
  output logic             ERR_OUT
);

  localparam int PW = $clog2(P_LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(P_LQ_DEPTH);

  logic [P_IDX-1:0]      q_idx [P_LQ_DEPTH];
  logic [31:0]           q_dat [P_LQ_DEPTH];
  logic [P_LQ_DEPTH-1:0] q_vld;
  logic [P_LQ_DEPTH-1:0] q_fil;

  logic [PW-1:0] tail;
  logic [PW-1:0] fill;
  logic [PW-1:0] head;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic iss_ok;
  logic iss_bad;
  logic rsp_ok;
  logic rsp_bad;
  logic ret;

  assign iss_ok  = LD_ISSUE_IN && LD_RDY_OUT;
  assign iss_bad = LD_ISSUE_IN && !LD_RDY_OUT;
  assign rsp_ok  = LD_VLD_IN && q_vld[fill] && !q_fil[fill];
  assign rsp_bad = LD_VLD_IN && !(q_vld[fill] && !q_fil[fill]);
  assign ret     = !ALU_VLD_IN && q_vld[head] && q_fil[head];
  assign cnt_nxt = cnt + CW'(iss_ok) - CW'(ret);

  always_ff @(posedge CLK_IN) begin
    if (iss_ok) q_idx[tail] <= LD_ISSUE_IDX_IN;
    if (rsp_ok) q_dat[fill] <= LD_DAT_IN;
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      q_vld <= '0;
      q_fil <= '0;
    end else begin
      for (int i = 0; i < P_LQ_DEPTH; i++) begin
        if (iss_ok && tail == PW'(i)) begin
          q_vld[i] <= 1'b1;
          q_fil[i] <= 1'b0;
        end
        if (rsp_ok && fill == PW'(i)) q_fil[i] <= 1'b1;
        if (ret && head == PW'(i)) begin
          q_vld[i] <= 1'b0;
          q_fil[i] <= 1'b0;
        end
      end
    end
  end

  // Ready tracks the next count so a full queue refuses the following issue.
  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      tail       <= '0;
      fill       <= '0;
      head       <= '0;
      cnt        <= '0;
      LD_RDY_OUT <= 1'b1;
      ERR_OUT    <= 1'b0;
    end else begin
      if (iss_ok) tail <= tail + 1'b1;
      if (rsp_ok) fill <= fill + 1'b1;
      if (ret)    head <= head + 1'b1;
      cnt        <= cnt_nxt;
      LD_RDY_OUT <= (cnt_nxt != FULL);
      if (iss_bad || rsp_bad) ERR_OUT <= 1'b1;
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_IN) begin
    if (!RST_IN) begin
      RD_WR_OUT  <= 1'b0;
      RD_IDX_OUT <= '0;
      RD_DAT_OUT <= '0;
    end else begin
      unique case (1'b1)
        ALU_VLD_IN: begin
          RD_WR_OUT  <= (ALU_IDX_IN != '0);
          RD_IDX_OUT <= ALU_IDX_IN;
          RD_DAT_OUT <= ALU_DAT_IN;
        end
        ret: begin
          RD_WR_OUT  <= (q_idx[head] != '0);
          RD_IDX_OUT <= q_idx[head];
          RD_DAT_OUT <= q_dat[head];
        end
        default: RD_WR_OUT <= 1'b0;
      endcase
    end
  end

  always_comb begin
    HAZ_OUT = 1'b0;
    for (int i = 0; i < P_LQ_DEPTH; i++) begin
      if (q_vld[i] && (
          (DEC_RS1_IDX_IN != '0 && q_idx[i] == DEC_RS1_IDX_IN) ||
          (DEC_RS2_IDX_IN != '0 && q_idx[i] == DEC_RS2_IDX_IN) ||
          (DEC_RD_IDX_IN  != '0 && q_idx[i] == DEC_RD_IDX_IN)))
        HAZ_OUT = 1'b1;
    end
  end

  assign RS1_FWD_OUT = RD_WR_OUT && RD_IDX_OUT == DEC_RS1_IDX_IN &&
                       DEC_RS1_IDX_IN != '0;
  assign RS2_FWD_OUT = RD_WR_OUT && RD_IDX_OUT == DEC_RS2_IDX_IN &&
                       DEC_RS2_IDX_IN != '0;

endmodule
